// File: rtl/aes_dec_feeder_pkg.sv
// Shared types and constants for the AES decoder feeder: FSM encoding, key
// schedule constants and the forward S-box used by the key expansion step.
package aes_dec_feeder_pkg;

    localparam int         AES_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_dec_feeder_key_step.sv
// One forward AES-128 key-schedule round: RotWord, SubWord, rcon and the
// word XOR chain. Purely combinational.
module aes_key_expand_step
    import aes_dec_feeder_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
    end

    assign temp = sub ^ {rcon, 24'h000000};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_dec_feeder.sv
// Front end for an iterative AES-128 decoder: expands the cipher key to round
// key 10, then issues ciphertext blocks one at a time with a 1-entry buffer.
module aes_dec_feeder
    import aes_dec_feeder_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         key_v_i,
    input  logic [127:0] key_i,
    output logic         key_ready_o,
    input  logic         data_v_i,
    input  logic [127:0] data_i,
    output logic         data_ready_o,
    output logic         dec_data_v_o,
    output logic [127:0] dec_data_o,
    output logic [127:0] dec_key_o,
    input  logic         dec_res_v_i,
    output logic         busy_o
);

    state_t       state, state_nxt;
    logic [127:0] key_q, key_step;
    logic [3:0]   round_cnt;
    logic [7:0]   rcon_q;
    logic         buf_v;
    logic [127:0] buf_data;
    logic         dec_v_q;
    logic [127:0] dec_data_q;

    logic         key_acc, data_acc;
    logic         issue, buf_load, buf_take;
    logic [127:0] issue_data;

    aes_key_expand_step u_step (
        .key      (key_q),
        .rcon     (rcon_q),
        .next_key (key_step)
    );

    always_comb begin
        state_nxt    = state;
        key_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        case (state)
            IDLE: begin
                key_ready_o = 1'b1;
                if (key_v_i) state_nxt = EXPAND;
            end
            EXPAND: begin
                if (round_cnt == 4'(AES_ROUNDS - 1)) state_nxt = READY;
            end
            READY: begin
                // Buffer is always empty here; a pending key blocks data.
                key_ready_o  = 1'b1;
                data_ready_o = !key_v_i;
                if (key_v_i)       state_nxt = EXPAND;
                else if (data_v_i) state_nxt = WAIT;
            end
            WAIT: begin
                data_ready_o = !buf_v;
                if (dec_res_v_i && !buf_v && !data_v_i) state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign key_acc  = key_v_i  && key_ready_o;
    assign data_acc = data_v_i && data_ready_o;

    always_comb begin
        issue      = 1'b0;
        issue_data = data_i;
        buf_load   = 1'b0;
        buf_take   = 1'b0;
        if (state == READY) begin
            issue = data_acc;
        end else if (state == WAIT) begin
            if (dec_res_v_i) begin
                // Decoder just went idle: drain the buffer, else bypass a new block.
                if (buf_v) begin
                    issue      = 1'b1;
                    issue_data = buf_data;
                    buf_take   = 1'b1;
                end else begin
                    issue = data_acc;
                end
            end else begin
                buf_load = data_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            buf_v     <= 1'b0;
            round_cnt <= 4'd0;
            rcon_q    <= RCON_INIT;
            dec_v_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            dec_v_q <= issue;
            if (key_acc) begin
                round_cnt <= 4'd0;
                rcon_q    <= RCON_INIT;
            end else if (state == EXPAND) begin
                round_cnt <= round_cnt + 4'd1;
                rcon_q    <= xtime(rcon_q);
            end
            if (buf_load)      buf_v <= 1'b1;
            else if (buf_take) buf_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (key_acc)              key_q <= key_i;
        else if (state == EXPAND) key_q <= key_step;
        if (issue)    dec_data_q <= issue_data;
        if (buf_load) buf_data   <= data_i;
    end

    assign dec_data_v_o = dec_v_q;
    assign dec_data_o   = dec_data_q;
    assign dec_key_o    = key_q;
    assign busy_o       = (state != READY) || buf_v;

endmodule

// File: tb/tb_aes_dec_feeder.sv
// Bench for aes_dec_feeder: transaction-level model with an independently
// derived S-box, a latency-driven decoder stand-in, and directed vectors.
module tb_aes_dec_feeder;

    localparam int LAT = 11;
    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KC = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset, key_v_i, data_v_i, force_res, auto_res;
    logic [127:0] key_i, data_i;
    logic         key_ready_o, data_ready_o, dec_data_v_o, busy_o;
    logic [127:0] dec_data_o, dec_key_o;
    logic         dec_res_v_i;

    int errs = 0;
    int checks = 0;
    int issues = 0;

    assign dec_res_v_i = auto_res | force_res;
    always #5 clk = ~clk;

    aes_dec_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .key_v_i      (key_v_i),
        .key_i        (key_i),
        .key_ready_o  (key_ready_o),
        .data_v_i     (data_v_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .dec_data_v_o (dec_data_v_o),
        .dec_data_o   (dec_data_o),
        .dec_key_o    (dec_key_o),
        .dec_res_v_i  (dec_res_v_i),
        .busy_o       (busy_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // GF(2^8) arithmetic: S-box derived from inverse + affine map, not a table.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [7:0] inv = 8'h01;
        if (b == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] rk10(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[40], w[41], w[42], w[43]};
    endfunction

    // Transaction model state
    bit           m_loaded = 0;
    int           m_exp_left = 0;
    bit           m_engaged = 0;
    logic [127:0] m_q[$];
    bit           m_issue = 0;
    logic [127:0] m_issue_data = '0;
    logic [127:0] m_rk = '0;

    function automatic bit m_ready();
        return m_loaded && (m_exp_left == 0) && !m_engaged;
    endfunction
    function automatic bit exp_key_ready();
        return !m_loaded || m_ready();
    endfunction
    function automatic bit exp_data_ready();
        if (m_ready()) return !key_v_i;
        if (m_engaged) return m_q.size() == 0;
        return 1'b0;
    endfunction

    initial begin : model
        bit rdy, kacc, dacc, nissue;
        logic [127:0] ndata;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_loaded = 0; m_exp_left = 0; m_engaged = 0; m_issue = 0;
                m_q.delete();
            end else begin
                rdy = m_ready();
                kacc = key_v_i && exp_key_ready();
                dacc = data_v_i && exp_data_ready();
                nissue = 0;
                ndata = '0;
                if (kacc) begin
                    m_loaded = 1; m_exp_left = 10; m_rk = rk10(key_i);
                end else if (m_exp_left > 0) begin
                    m_exp_left--;
                end
                if (rdy && dacc) begin
                    nissue = 1; ndata = data_i; m_engaged = 1;
                end else if (m_engaged) begin
                    if (dec_res_v_i) begin
                        if (m_q.size() > 0) begin nissue = 1; ndata = m_q.pop_front(); end
                        else if (dacc) begin nissue = 1; ndata = data_i; end
                        else m_engaged = 0;
                    end else if (dacc) begin
                        m_q.push_back(data_i);
                    end
                end
                m_issue = nissue;
                m_issue_data = ndata;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("key_ready", key_ready_o, exp_key_ready());
            chk("data_ready", data_ready_o, exp_data_ready());
            chk("busy", busy_o, !m_ready() || m_q.size() > 0);
            chk("dec_v", dec_data_v_o, m_issue);
            chk("issue_vs_res", dec_data_v_o && dec_res_v_i, 0);
            if (m_issue) chk("dec_data", dec_data_o, m_issue_data);
            if (m_loaded && m_exp_left == 0) chk("dec_key", dec_key_o, m_rk);
            if (dec_data_v_o) issues++;
        end
    end

    initial begin : decoder
        int dcnt = 0;
        auto_res = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (dec_data_v_o) begin
                dcnt = LAT; auto_res = 1'b0;
            end else if (dcnt > 0) begin
                dcnt--; auto_res = (dcnt == 0);
            end else begin
                auto_res = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        int n = 0;
        key_v_i = 1'b1; key_i = k;
        @(negedge clk);
        while (!key_ready_o && n < 200) begin @(negedge clk); n++; end
        chk("key_accept_timeout", n < 200, 1);
        tick();
        key_v_i = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, output int waited);
        int n = 0;
        data_v_i = 1'b1; data_i = d;
        @(negedge clk);
        while (!data_ready_o && n < 200) begin @(negedge clk); n++; end
        chk("data_accept_timeout", n < 200, 1);
        tick();
        data_v_i = 1'b0;
        waited = n;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (busy_o && n < 300) begin @(negedge clk); n++; end
        chk("ready_timeout", n < 300, 1);
        tick();
    endtask

    initial begin : stim
        int w1, w2, w3, base;
        reset = 1'b1; key_v_i = 1'b0; data_v_i = 1'b0; force_res = 1'b0;
        key_i = '0; data_i = '0;

        chk("model_rk_a", rk10(KA), 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_rk_b", rk10(KB), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        tick(); tick();
        @(negedge clk);
        chk("rst_key_ready", key_ready_o, 1);
        chk("rst_data_ready", data_ready_o, 0);
        chk("rst_busy", busy_o, 1);
        chk("rst_dec_v", dec_data_v_o, 0);
        tick();
        reset = 1'b0;

        // Key A: READY exactly 10 cycles after acceptance
        load_key(KA);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("expand_cycle10", key_ready_o, 0);
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_10", key_ready_o, 1);
        chk("ready_data_rdy", data_ready_o, 1);
        chk("rk10_a_literal", dec_key_o, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        tick();

        // Key B and one block issued one cycle after acceptance
        load_key(KB);
        wait_ready();
        @(negedge clk);
        chk("rk10_b_literal", dec_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        send_block(CT, w1);
        @(negedge clk);
        chk("issue_1cycle", dec_data_v_o, 1);
        chk("issue_data", dec_data_o, CT);
        chk("issue_key", dec_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        wait_ready();

        // Three back-to-back blocks
        base = issues;
        send_block(128'h11111111222222223333333344444444, w1);
        send_block(128'h55555555666666667777777788888888, w2);
        send_block(128'h99999999aaaaaaaabbbbbbbbcccccccc, w3);
        chk("first_no_wait", w1, 0);
        chk("second_buffered", w2, 0);
        chk("third_stalls", w3 > 5, 1);
        wait_ready();
        chk("three_issues", issues - base, 3);

        // dec_res_v_i in READY is ignored
        force_res = 1'b1;
        tick();
        force_res = 1'b0;
        @(negedge clk);
        chk("res_in_ready_kr", key_ready_o, 1);
        chk("res_in_ready_busy", busy_o, 0);
        chk("res_in_ready_dv", dec_data_v_o, 0);
        tick();

        // Key and data together in READY: key wins
        key_v_i = 1'b1; key_i = KC; data_v_i = 1'b1; data_i = CT;
        @(negedge clk);
        chk("collide_data_rdy", data_ready_o, 0);
        chk("collide_key_rdy", key_ready_o, 1);
        tick();
        key_v_i = 1'b0; data_v_i = 1'b0;
        @(negedge clk);
        chk("collide_expand_kr", key_ready_o, 0);
        chk("collide_no_issue", dec_data_v_o, 0);
        tick();
        wait_ready();

        // Reset on the 5th EXPAND cycle
        load_key(KA);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midexp_rst_kr", key_ready_o, 1);
        chk("midexp_rst_dr", data_ready_o, 0);
        chk("midexp_rst_dv", dec_data_v_o, 0);
        chk("midexp_rst_busy", busy_o, 1);
        tick();

        // Recovery after reset
        load_key(KC);
        wait_ready();
        send_block(128'hdeadbeef0123456789abcdeffedcba98, w1);
        wait_ready();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
